// File: rtl/cop_wb_fifo_if.sv
// cop_wb_fifo_if: bundles the ISE result-write handshake and the register-file
// writeback handshake of the coprocessor writeback FIFO.
//   cop_insn  [31:0] instruction presented to the ISE, rd in [11:7]
//   cop_wr           ISE result-write request
//   cop_rd    [63:0] ISE result data
//   cop_rdywr        write accept back to the ISE
//   wb_valid         head entry available
//   wb_ready         register file takes the head entry this cycle
//   wb_addr   [4:0]  head entry destination register
//   wb_data   [63:0] head entry data
//   wb_pend   [31:0] registers with at least one queued result
// Modport slave is the FIFO side, master is the ISE / register-file side.
interface cop_wb_fifo_if;
    logic [31:0] cop_insn;
    logic        cop_wr;
    logic [63:0] cop_rd;
    logic        cop_rdywr;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [31:0] wb_pend;

    modport slave (
        input  cop_insn, cop_wr, cop_rd, wb_ready,
        output cop_rdywr, wb_valid, wb_addr, wb_data, wb_pend
    );

    modport master (
        output cop_insn, cop_wr, cop_rd, wb_ready,
        input  cop_rdywr, wb_valid, wb_addr, wb_data, wb_pend
    );
endinterface

// File: rtl/cop_wb_fifo.sv
// cop_wb_fifo: queues ISE results {rd, data} in strict FIFO order and presents
// the head to the core register file. Also publishes a pending-register mask
// so the core can interlock on registers whose results have not landed yet.
// Ports:
//   cop_clk  clock, all state updates on the rising edge
//   cop_rst  asynchronous reset, active low
//   bus      cop_wb_fifo_if.slave (ISE write side + writeback side)
// Parameter DEPTH: number of entries, power of two, 2 or more.

// One storage slot: holds {rd, data} and decodes its own contribution to the
// pending mask. Storage is deliberately not reset; validity lives in the
// occupancy counter of the parent.
module cop_wb_fifo_ent (
    input  logic        cop_clk,
    input  logic        we,
    input  logic [4:0]  addr_in,
    input  logic [63:0] data_in,
    input  logic        vld,
    output logic [4:0]  addr,
    output logic [63:0] data,
    output logic [31:0] pend
);
    always_ff @(posedge cop_clk) begin
        if (we) begin
            addr <= addr_in;
            data <= data_in;
        end
    end

    // x0 is never enqueued, but keep bit 0 clear regardless of slot contents.
    always_comb begin
        pend = '0;
        if (vld) pend = 32'd1 << addr;
        pend[0] = 1'b0;
    end
endmodule

module cop_wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic          cop_clk,
    input  logic          cop_rst,
    cop_wb_fifo_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, accept, push, pop;
    logic [4:0] ins_rd;

    logic [DEPTH-1:0]       ent_we, ent_vld;
    logic [DEPTH-1:0][4:0]  ent_addr;
    logic [DEPTH-1:0][63:0] ent_data;
    logic [DEPTH-1:0][31:0] ent_pend;

    // Only rd is consumed from the instruction word.
    logic unused_insn;
    assign unused_insn = ^{bus.cop_insn[31:12], bus.cop_insn[6:0]};

    assign ins_rd = bus.cop_insn[11:7];

    // Accept is decoded from registered occupancy only, so a pop while full
    // does not free a slot until the following cycle.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign accept = bus.cop_wr & ~full;
    // Writes to x0 complete the handshake but are dropped.
    assign push   = accept & (ins_rd != 5'd0);
    // No bypass: an empty FIFO never pops, even when a push lands this cycle.
    assign pop    = ~empty & bus.wb_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) tail_q <= tail_q + AW'(1);
            if (pop)  head_q <= head_q + AW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [AW-1:0] ofs;

            // Slot is live when its distance from head is below occupancy;
            // the AW-bit subtraction wraps modulo DEPTH.
            assign ofs            = IDX - head_q;
            assign ent_vld[gi]    = ({1'b0, ofs} < count_q);
            assign ent_we[gi]     = push & (tail_q == IDX);

            cop_wb_fifo_ent u_ent (
                .cop_clk (cop_clk),
                .we      (ent_we[gi]),
                .addr_in (ins_rd),
                .data_in (bus.cop_rd),
                .vld     (ent_vld[gi]),
                .addr    (ent_addr[gi]),
                .data    (ent_data[gi]),
                .pend    (ent_pend[gi])
            );
        end
    endgenerate

    always_comb begin
        bus.wb_pend = '0;
        for (int i = 0; i < DEPTH; i++) bus.wb_pend = bus.wb_pend | ent_pend[i];
    end

    // Head is read straight out of storage; masked while empty so stale or
    // uninitialised slot contents never leak out (including during reset).
    assign bus.cop_rdywr = ~full;
    assign bus.wb_valid  = ~empty;
    assign bus.wb_addr   = empty ? 5'd0  : ent_addr[head_q];
    assign bus.wb_data   = empty ? 64'd0 : ent_data[head_q];
endmodule

// File: doc/cop_wb_fifo.md
COP_WB_FIFO -- requirements
Module: cop_wb_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of result entries; legal values are powers of two, 2 or more.
REQ-002 The block SHALL have port cop_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port cop_rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have port cop_insn, input, 32 bits: the instruction currently presented to the ISE; bits [11:7] give the destination register index (rd).
REQ-005 The block SHALL have port cop_wr, input, 1 bit: the ISE result-write request.
REQ-006 The block SHALL have port cop_rd, input, 64 bits: the ISE result data, valid while cop_wr is high.
REQ-007 The block SHALL have port cop_rdywr, output, 1 bit: the write-accept signal back to the ISE.
REQ-008 The block SHALL have port wb_valid, output, 1 bit: a writeback entry is available.
REQ-009 The block SHALL have port wb_ready, input, 1 bit: the core register file accepts the writeback this cycle.
REQ-010 The block SHALL have port wb_addr, output, 5 bits: the destination register index of the head entry.
REQ-011 The block SHALL have port wb_data, output, 64 bits: the result data of the head entry.
REQ-012 The block SHALL have port wb_pend, output, 32 bits: bit i is set when any valid entry targets register i; bit 0 is always 0.

Function
REQ-013 cop_rdywr SHALL equal NOT full, decoded from registered occupancy only; there is no same-cycle bypass from a pop while full.
REQ-014 Push condition: cop_wr = 1, cop_rdywr = 1 and cop_insn[11:7] != 0; on push, {cop_insn[11:7], cop_rd} SHALL be written at the tail, and the tail SHALL advance modulo DEPTH.
REQ-015 When cop_wr = 1, cop_rdywr = 1 and rd = 0, the write SHALL be accepted (the handshake completes) but discarded, with no enqueue.
REQ-016 When cop_wr = 1 and cop_rdywr = 0, no state SHALL change; the ISE holds cop_wr and cop_rd until acceptance.
REQ-017 Pop condition: wb_valid = 1 and wb_ready = 1; on pop, the head SHALL advance modulo DEPTH.
REQ-018 wb_valid SHALL equal NOT empty; wb_addr and wb_data SHALL present the head entry directly from storage, with no extra register stage.
REQ-019 Latency: an entry pushed at edge N SHALL be visible on wb_valid, wb_addr and wb_data in the cycle after edge N; the FIFO SHALL NOT bypass when empty.
REQ-020 A simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged and advance both pointers.
REQ-021 A simultaneous push and pop when empty SHALL perform the push only; when full, the pop only (cop_rdywr = 0).
REQ-022 Occupancy SHALL be a counter of width log2(DEPTH)+1; full = (count == DEPTH), empty = (count == 0); pointers wrap without skipping entries.
REQ-023 Ordering SHALL be strict FIFO; results are never reordered or merged, and duplicate rd entries are kept separately.
REQ-024 wb_pend SHALL be the combinational OR of one-hot(rd) over all valid entries; a register is cleared from the mask only when its last pending entry pops.
REQ-025 When wb_ready = 1 and wb_valid = 0, the block SHALL ignore wb_ready with no effect.

Reset
REQ-026 While cop_rst = 0, the block SHALL asynchronously clear count, head and tail, giving wb_valid = 0, wb_pend = 0 and cop_rdywr = 1.
REQ-027 During reset, wb_addr and wb_data SHALL read as 0; entry storage need not be cleared, but outputs SHALL be masked to 0 while empty.
REQ-028 Reset asserted mid-operation SHALL flush all pending entries with no writeback emitted; a push or pop coincident with reset release edge SHALL be ignored.

Verification
REQ-029 Single write: after reset, cop_insn[11:7] = 5 and cop_rd = 0x0123456789ABCDEF with cop_wr pulsed for 1 cycle and wb_ready = 1 -> next cycle wb_valid = 1, wb_addr = 5, wb_data = 0x0123456789ABCDEF, wb_pend = 0x20; one cycle later wb_valid = 0 and wb_pend = 0.
REQ-030 Fill/stall: DEPTH = 2, wb_ready = 0, three back-to-back writes to rd 1, 2 and 3 -> first two accepted; cop_rdywr = 0 while the third is held; wb_pend = 0x6.
REQ-031 Fill/stall drain: raise wb_ready -> pops rd 1, 2 and 3 in order; cop_rdywr returns to 1 the cycle after the first pop; the third write is accepted then.
REQ-032 x0 discard: cop_wr with rd = 0 -> cop_rdywr = 1, wb_valid stays 0, and count is unchanged.
REQ-033 Concurrent push/pop: count = 1, push rd 7 and pop in the same cycle -> count stays 1, head becomes rd 7, and wb_pend = 0x80.
REQ-034 Mid-operation reset: two entries pending, cop_rst pulled low asynchronously between edges -> wb_valid = 0 and wb_pend = 0 immediately; no writeback occurs after release.
